// File: rtl/rv_pkg.sv
// Shared RV32IM execute-stage definitions: ALU operation codes and MDU state encoding.
package rv_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu(input logic [ALU_OP_W-1:0] op);
    return op >= ALU_OP_W'(OP_MUL);
  endfunction

  function automatic logic is_div(input logic [ALU_OP_W-1:0] op);
    return op >= ALU_OP_W'(OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: sign-magnitude operands, one shift-add or
// restoring-subtract step per cycle, sign correction and corner overrides in FIX.
module mdu_iterative
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MDU_STEPS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                start_i,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     result_o
);

  localparam int CNT_W = $clog2(MDU_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MDU_STEPS - 1);

  mdu_state_e          state_q;
  alu_op_e             op_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     ma_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic                neg_rem_q;
  logic                b_zero_q;

  alu_op_e         op_in;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in = alu_op_e'(op_i);
  assign sa    = a_i[XLEN-1] && (op_in == OP_MULH || op_in == OP_MULHSU ||
                                 op_in == OP_DIV  || op_in == OP_REM);
  assign sb    = b_i[XLEN-1] && (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // acc_q holds {product high, multiplier} for mul and {remainder, quotient} for div.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] acc_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ok    = div_shift >= {1'b0, ma_q};
    div_rem   = div_shift[XLEN-1:0] - ma_q;
    if (is_div(op_q)) begin
      acc_d = div_ok ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                     : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      ma_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_CALC;
            op_q      <= op_in;
            a_q       <= a_i;
            cnt_q     <= '0;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            b_zero_q  <= (b_i == '0);
            if (is_div(op_i)) begin
              ma_q  <= mag_b;
              acc_q <= {{XLEN{1'b0}}, mag_a};
            end else begin
              ma_q  <= mag_a;
              acc_q <= {{XLEN{1'b0}}, mag_b};
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_FIX;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quot_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        result_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result_o = b_zero_q ? '1 : quot_s;
      OP_REM, OP_REMU:               result_o = b_zero_q ? a_q : rem_s;
      default:                       result_o = '0;
    endcase
  end

  assign busy_o = !flush_i && ((state_q == ST_IDLE && start_i) || state_q == ST_CALC);
  assign done_o = (state_q == ST_FIX);

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle RV32I ALU, iterative RV32M unit with upstream stall,
// and the EX/MEM pipeline register.
module execute_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MDU_STEPS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     operand_a,
  input  logic [XLEN-1:0]     operand_b,
  input  logic [XLEN-1:0]     rs2_in,
  input  logic [4:0]          rd_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                reg_write_in,
  input  logic                flush,
  output logic                stall,
  output logic                valid_out,
  output logic [XLEN-1:0]     alu_result,
  output logic [XLEN-1:0]     rs2_data,
  output logic [4:0]          rd,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write
);

  logic            mdu_busy, mdu_done;
  logic [XLEN-1:0] mdu_result;

  mdu_iterative #(
    .XLEN      (XLEN),
    .MDU_STEPS (MDU_STEPS)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .start_i  (valid_in && is_mdu(alu_op)),
    .op_i     (alu_op),
    .a_i      (operand_a),
    .b_i      (operand_b),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );

  assign stall = mdu_busy;

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_y;

  assign shamt = operand_b[4:0];

  always_comb begin
    alu_y = '0;
    case (alu_op_e'(alu_op))
      OP_ADD:   alu_y = operand_a + operand_b;
      OP_SUB:   alu_y = operand_a - operand_b;
      OP_SLL:   alu_y = operand_a << shamt;
      OP_SLT:   alu_y = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU:  alu_y = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      OP_XOR:   alu_y = operand_a ^ operand_b;
      OP_SRL:   alu_y = operand_a >> shamt;
      OP_SRA:   alu_y = $unsigned($signed(operand_a) >>> shamt);
      OP_OR:    alu_y = operand_a | operand_b;
      OP_AND:   alu_y = operand_a & operand_b;
      OP_PASSB: alu_y = operand_b;
      default:  alu_y = '0;
    endcase
  end

  // Flush beats a finishing MDU op; a busy MDU or an empty ID/EX inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      alu_result <= '0;
      rs2_data   <= '0;
      rd         <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
    end else if (!flush && (mdu_done || (valid_in && !mdu_busy))) begin
      valid_out  <= 1'b1;
      alu_result <= mdu_done ? mdu_result : alu_y;
      rs2_data   <= rs2_in;
      rd         <= rd_in;
      mem_read   <= mem_read_in;
      mem_write  <= mem_write_in;
      reg_write  <= reg_write_in;
    end else begin
      valid_out  <= 1'b0;
      alu_result <= '0;
      rs2_data   <= '0;
      rd         <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
    end
  end

endmodule
